hazard_stall_ctrl: RTL

Pipeline sequencing controller for the 5-stage RISC-V core, sitting in ID beside the forwarding unit. It covers the hazards forwarding cannot resolve: load-use stalls, taken-branch flushes and multi-cycle data-memory waits. It drives the write-enable, bubble and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. A small FSM plus a wait-timeout counter guarantees exactly one bubble per load-use and bounded memory freezes.

---
 rtl/hazard_stall_ctrl.sv | 94 +++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use stall, branch flush and data-memory freeze sequencing; HAZ_CTRL_PERF_EN adds stall/flush counters
module hazard_stall_ctrl #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] IF_ID_Rs1,
  input  logic [4:0] IF_ID_Rs2,
  input  logic [4:0] ID_EX_Rd,
  input  logic       ID_EX_MemRead,
  input  logic       EX_BranchTaken,
  input  logic       EX_MEM_MemReq,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       id_ex_write,
  output logic       ex_mem_write,
  output logic       id_ex_bubble,
  output logic       mem_wb_bubble,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       mem_timeout,
`ifdef HAZ_CTRL_PERF_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  output logic [1:0] ctrl_state
);
  localparam int CW = $clog2(MEM_WAIT_MAX + 1);
  typedef enum logic [1:0] {RUN = 2'b00, LOAD_STALL = 2'b01, MEM_WAIT = 2'b10} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic freeze, luse, waiting, wait_hold, frz_now;
  assign freeze    = EX_MEM_MemReq && !mem_ready;
  assign luse      = ID_EX_MemRead && ID_EX_Rd != 5'd0 && (ID_EX_Rd == IF_ID_Rs1 || ID_EX_Rd == IF_ID_Rs2);
  assign waiting   = state == MEM_WAIT;
  assign wait_hold = waiting && !mem_ready && cnt < CW'(MEM_WAIT_MAX);
  assign frz_now   = waiting ? wait_hold : freeze;
  assign ctrl_state = rst ? state : RUN;
  // A release cycle (ready or timeout) is evaluated like RUN so a held branch or load-use is acted on then
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    id_ex_bubble  = 1'b0;
    mem_wb_bubble = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_timeout   = rst && waiting && !mem_ready && !wait_hold;
    state_nx      = RUN;
    cnt_nx        = '0;
    if (!rst) begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
      id_ex_bubble  = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (frz_now) begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
      mem_wb_bubble = 1'b1;
      state_nx      = MEM_WAIT;
      cnt_nx        = waiting ? cnt + 1'b1 : '0;
    end else if (EX_BranchTaken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (luse && state != LOAD_STALL) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      state_nx     = LOAD_STALL;
    end
  end
  // State and wait counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end
`ifdef HAZ_CTRL_PERF_EN
  // Saturating stall and flush cycle counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      if (if_id_flush && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif
endmodule
